buf_delay_sched: RTL

- Scheduler that shares one programmable delay element (min/typ/max = 3/4/5 cycles) among NREQ requesters.
- Round-robin arbitration picks one requester and latches its data word.
- Data is held for the selected delay, then presented once on the shared output, tagged with the requester id.
- Sits between requester logic and a single shared timing path; only one operation is in flight at a time.

---
 rtl/buf_delay_pkg.sv | 27 ++
 rtl/buf_delay_sched_rr_arbiter.sv | 42 ++++
 rtl/buf_delay_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/buf_delay_pkg.sv
// rtl/buf_delay_pkg.sv - shared types and delay-select decode for buf_delay_sched
//
// Purpose: FSM state encoding, dly_sel codes and the dly_sel -> delay mapping.

package buf_delay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_EMIT  = 2'd2
  } state_e;

  localparam logic [1:0] SEL_MIN = 2'd0;
  localparam logic [1:0] SEL_TYP = 2'd1;
  localparam logic [1:0] SEL_MAX = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  // The reserved code falls back to the typical delay.
  function automatic int sel_to_dly(logic [1:0] sel, int dmin, int dtyp, int dmax);
    case (sel)
      SEL_MIN: return dmin;
      SEL_MAX: return dmax;
      default: return dtyp;
    endcase
  endfunction

endpackage

// File: rtl/buf_delay_sched_rr_arbiter.sv
// rtl/buf_delay_sched_rr_arbiter.sv - combinational round-robin arbiter
//
// Purpose: picks the first set request at or after ptr_i, wrapping modulo NREQ.
// Ports:
//   req_i     request vector
//   ptr_i     highest-priority index
//   enable_i  arbitration enable; no grant when low
//   grant_o   one-hot grant (combinational)
//   idx_o     index of the granted requester
//   valid_o   a grant is present

module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            enable_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  always_comb begin
    int unsigned j;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      j = (32'(ptr_i) + i) % NREQ;
      if (enable_i && !found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/buf_delay_sched.sv
// rtl/buf_delay_sched.sv - round-robin scheduler sharing one programmable delay element
//
// Purpose: grants one requester at a time, holds its data word for 3/4/5 cycles
// (selected by dly_sel at grant) and presents it once, tagged with the requester id.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req, din    per-requester request and packed data (slice i = requester i)
//   dly_sel     delay select, sampled in the grant cycle
//   gnt         registered one-hot grant pulse
//   busy        operation in flight
//   dout, dout_valid, dout_id   delayed data, 1-cycle valid pulse, owner index

module buf_delay_sched
  import buf_delay_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int CW      = 4,
  parameter int DLY_MIN = 3,
  parameter int DLY_TYP = 4,
  parameter int DLY_MAX = 5,
  localparam int IW = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] din,
  input  logic [1:0]       dly_sel,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic [DW-1:0]    dout,
  output logic             dout_valid,
  output logic [IW-1:0]    dout_id
);

  localparam int CMAX = (2 ** CW) - 1;

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("buf_delay_sched: NREQ must be 2..8");
  end
  if (DLY_MIN < 1 || DLY_MIN > CMAX || DLY_TYP < 1 || DLY_TYP > CMAX ||
      DLY_MAX < 1 || DLY_MAX > CMAX) begin : g_bad_dly
    $error("buf_delay_sched: each DLY_* must be within 1..2**CW-1");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [DW-1:0]   data_q, data_d;
  logic [IW-1:0]   id_q, id_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            dv_q, dv_d;
  logic [IW-1:0]   dout_id_q, dout_id_d;

  logic [NREQ-1:0] arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_valid;
  int              dly;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .enable_i (state_q == ST_IDLE),
    .grant_o  (arb_grant),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  // dout_valid is registered out of EMIT, so EMIT is entered at T+D-1 and the
  // pulse lands at T+D. The FSM is back in IDLE during the pulse cycle, which
  // lets the next grant appear at T+D+1.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    data_d    = data_q;
    id_d      = id_q;
    dout_d    = dout_q;
    dv_d      = 1'b0;
    dout_id_d = dout_id_q;
    dly       = sel_to_dly(dly_sel, DLY_MIN, DLY_TYP, DLY_MAX);

    if (dv_q) busy_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d  = arb_grant;
          data_d = din[arb_idx*DW +: DW];
          id_d   = arb_idx;
          cnt_d  = CW'(dly - 1);
          busy_d = 1'b1;
          ptr_d  = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d = (dly == 1) ? ST_EMIT : ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (cnt_q == CW'(1)) state_d = ST_EMIT;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      ST_EMIT: begin
        dv_d      = 1'b1;
        dout_d    = data_q;
        dout_id_d = id_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      data_q    <= '0;
      id_q      <= '0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      dout_id_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
      id_q      <= id_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      dout_id_q <= dout_id_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign dout_id    = dout_id_q;

endmodule
